min_sort_drain: RTL and testbench
=================================

# min_sort_drain

Sequential read-out stage for the min-sort selection network. It owns the active-candidate mask that feeds the network's `chi` inputs. Each pass it samples the network's `xi` winner vector, emits the winning element's data and index over a valid/ready stream, then retires that element from the mask. Repeating this until the mask is empty drains all loaded elements in ascending key order.

## Interface
Parameters:
- `N`, default from `sort_pkg::N` (8): number of sort slots; must match the selection network.
- `W`, default 16: data word width per slot.
- `IW`, default `$clog2(N)`: index width (derived; do not override).

Ports:
- `i_clk` in 1: clock; the only clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: start a drain pass; sampled only in IDLE.
- `i_mask` in N: slots holding valid elements; loaded on an accepted `i_start`.
- `o_active` out N: current active mask, driven to the selection network `chi` inputs.
- `i_xi` in N: winner vector returned combinationally by the network for `o_active`.
- `i_data` in N*W: slot data, flattened; slot k is `i_data[k*W +: W]`; must be stable for the whole pass.
- `o_valid` out 1: output word valid.
- `i_ready` in 1: downstream ready.
- `o_data` out W: winning slot data.
- `o_idx` out IW: winning slot index.
- `o_last` out 1: qualifies `o_valid`; this word is the final element of the pass.
- `o_busy` out 1: high in any state other than IDLE.
- `o_done` out 1: one-cycle pulse when a pass completes.
- `o_err` out 1: sticky; network returned no winner while the active mask was non-zero.

## Operation
- States: IDLE, SELECT, OUT.
- **IDLE**
  - `i_start`=1 with `i_mask`≠0: `active`←`i_mask`, go to SELECT.
  - `i_start`=1 with `i_mask`=0: pulse `o_done` the next cycle and stay in IDLE.
  - `i_start` in any state other than IDLE is ignored.
- **SELECT** (one cycle, lets the network settle on the registered `o_active`)
  - Compute `cand` = `i_xi` & `active`.
  - `cand`≠0: `idx`←lowest set bit of `cand`, `o_data`←slot `idx`, `o_idx`←`idx`, `o_last`←((`active` & ~onehot(`idx`))==0), `o_valid`←1, go to OUT.
  - `cand`=0: set `o_err`, clear `active`, go to IDLE, no `o_done` pulse.
- **Tie handling:** on a multi-hot `cand` (equal keys), the lowest index wins. Equal keys therefore drain in ascending index order. `i_xi` bits outside `active` are ignored.
- **OUT**
  - `o_data`, `o_idx` and `o_last` are held stable while `o_valid`=1 and `i_ready`=0.
  - On the handshake (`o_valid`&`i_ready`): clear `active[idx]` and drop `o_valid`.
  - If the new `active`=0: pulse `o_done` and go to IDLE. Otherwise go to SELECT.
- **`o_err`** clears only on `i_rst` or on an accepted `i_start`.
- **Reset:** `i_rst` at any time (including mid-pass) forces IDLE. All outputs go to 0: `o_active`, `o_valid`, `o_data`, `o_idx`, `o_last`, `o_busy`, `o_done`, `o_err`. Any in-flight word is discarded.

## Timing
- All outputs are registered. `o_active` is a register, so the network path is `o_active`→`i_xi` within one cycle.
- **First word:** `i_start` accepted at edge t. `o_active` valid after t. SELECT occupies cycle t+1. `o_valid`=1 from cycle t+2.
- **Subsequent words:** handshake at edge c. Updated `o_active` after c. SELECT in cycle c+1. Next `o_valid` in cycle c+2.
- **Throughput:** at most one word per 2 cycles. A pass of k elements takes ≥ 2k+1 cycles from `i_start` to `o_done`.
- `o_done` is asserted in the cycle following the final handshake; `o_busy` is already 0 in that cycle.
- Backpressure: unbounded stall in OUT; no timeout.

## Test plan
- **Basic pass.** N=4, W=8, `i_mask`=4'b1111, slot data {3:0x40, 2:0x10, 1:0x30, 0:0x20}. Stub network returns the one-hot of the min-data active slot. `i_ready`=1. Expect `o_idx` sequence 2,0,1,3 and `o_data` 0x10,0x20,0x30,0x40. `o_last` only on 0x40. First `o_valid` 2 cycles after `i_start`. `o_done` 1 cycle after the last handshake.
- **Ties and sparse mask.** `i_mask`=4'b1010, slots 3 and 1 both 0x55, network returns 4'b1010. Expect `o_idx` 1 then 3, `o_last` on idx 3. Slots 0 and 2 never appear.
- **Backpressure.** Basic pass with `i_ready` low for 5 cycles while the first word is valid. `o_data`=0x10 and `o_idx`=2 are held. `o_active` stays 4'b1111 until the handshake. Order of later words unchanged.
- **Empty / error.** `i_start` with `i_mask`=0: `o_done` pulses, `o_valid` never asserts. A pass where the network returns 0: `o_err`=1 and stays set through an idle period, clears on the next accepted `i_start`.
- **Mid-pass reset and ignored start.** Assert `i_rst` in OUT after 1 of 4 words. Next cycle all outputs are 0 and the state is IDLE. A new `i_start` completes a full 4-word pass. `i_start` pulsed while `o_busy`=1 has no effect on order or count.

Source files
------------

// File: rtl/min_sort_drain.sv
// Sequential drain stage: owns the active mask for a min-sort network and streams winners out in ascending key order.
// Latency: first word 2 cycles after an accepted start, then one word per 2 cycles (SELECT + OUT per element).
// Backpressure: valid/ready; a word is held stable in OUT for as long as ready stays low, with no timeout.

package sort_pkg;
    localparam int N = 8;
endpackage

module min_sort_drain #(
    parameter int N  = sort_pkg::N,
    parameter int W  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [N-1:0]    i_mask,
    output logic [N-1:0]    o_active,
    input  logic [N-1:0]    i_xi,
    input  logic [N*W-1:0]  i_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [W-1:0]    o_data,
    output logic [IW-1:0]   o_idx,
    output logic            o_last,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;

    logic [1:0]   state;
    logic [N-1:0] cand;
    logic         sel_hit;
    logic [IW-1:0] sel_idx;
    logic [W-1:0] sel_data;
    logic [N-1:0] sel_remain;
    logic [N-1:0] hs_active;

    // Pick the lowest-index winner among active slots; xi bits outside the mask are discarded.
    always_comb begin
        cand    = i_xi & o_active;
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand[k]) begin
                sel_hit = 1'b1;
                sel_idx = IW'(k);
            end
        end
        sel_data   = i_data[sel_idx*W +: W];
        sel_remain = o_active & ~(N'(1) << sel_idx);
        hs_active  = o_active & ~(N'(1) << o_idx);
    end

    // Drain FSM: load mask, select winner, present it, retire it on handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            o_active <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_idx    <= '0;
            o_last   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_err <= 1'b0;
                        if (|i_mask) begin
                            o_active <= i_mask;
                            o_busy   <= 1'b1;
                            state    <= S_SELECT;
                        end else begin
                            // Empty pass completes immediately.
                            o_done <= 1'b1;
                        end
                    end
                end
                S_SELECT: begin
                    if (sel_hit) begin
                        o_data  <= sel_data;
                        o_idx   <= sel_idx;
                        o_last  <= ~|sel_remain;
                        o_valid <= 1'b1;
                        state   <= S_OUT;
                    end else begin
                        // Network produced no winner for a non-empty mask: abandon the pass.
                        o_err    <= 1'b1;
                        o_active <= '0;
                        o_busy   <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (i_ready) begin
                        o_active <= hs_active;
                        o_valid  <= 1'b0;
                        if (~|hs_active) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_min_sort_drain.sv
// Directed bench for min_sort_drain with a behavioural min-select network stub.
// Latency: checks first word at start+2 and done one cycle after the final handshake.
// Backpressure: exercises a multi-cycle ready stall on the first word.

module tb_min_sort_drain;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  mask;
    logic [3:0]  active;
    logic [3:0]  xi;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic [7:0]  odata;
    logic [1:0]  oidx;
    logic        last;
    logic        busy;
    logic        done;
    logic        err;

    logic        force_en;
    logic [3:0]  xi_force;
    logic [3:0]  xi_stub;
    logic [7:0]  best;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] got_idx  [8];
    logic [7:0] got_data [8];
    logic       got_last [8];
    int         got_n;
    int         hs_cyc;
    int         done_cyc;
    logic       busy_at_done;

    min_sort_drain #(.N(4), .W(8)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_mask   (mask),
        .o_active (active),
        .i_xi     (xi),
        .i_data   (data),
        .o_valid  (valid),
        .i_ready  (ready),
        .o_data   (odata),
        .o_idx    (oidx),
        .o_last   (last),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub network: one-hot of the smallest active key, lowest index on ties.
    always_comb begin
        xi_stub = '0;
        best    = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            if (active[k] && (xi_stub == 4'b0000 || data[k*8 +: 8] < best)) begin
                best    = data[k*8 +: 8];
                xi_stub = 4'b0001 << k;
            end
        end
    end
    assign xi = force_en ? xi_force : xi_stub;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run until o_done, recording every handshake; optionally pulse i_start throughout.
    task automatic collect(input int budget, input bit noise);
        got_n        = 0;
        hs_cyc       = -100;
        done_cyc     = -1;
        busy_at_done = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (valid && ready && got_n < 8) begin
                got_idx[got_n]  = oidx;
                got_data[got_n] = odata;
                got_last[got_n] = last;
                got_n++;
                hs_cyc = c;
            end
            if (done) begin
                done_cyc     = c;
                busy_at_done = busy;
                break;
            end
            if (noise) start = (c % 3 == 1);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mask = '0; ready = 1'b0;
        force_en = 1'b0; xi_force = '0; data = '0;
        tick(); tick(); tick();
        n_cmp++;
        if ({active, valid, odata, oidx, last, busy, done, err} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0", {active, valid, odata, oidx, last, busy, done, err});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [1:0] exp_idx  [4];
        logic [7:0] exp_data [4];
        logic       exp_last [4];
        exp_idx  = '{2'd2, 2'd0, 2'd1, 2'd3};
        exp_data = '{8'h10, 8'h20, 8'h30, 8'h40};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        data = 32'h4010_3020; mask = 4'b1111; ready = 1'b1; force_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({valid, busy, active} !== {1'b0, 1'b1, 4'b1111}) begin
            n_err++;
            $display("FAIL basic_select_cycle: valid/busy/active %b required 011111", {valid, busy, active});
        end
        tick();
        n_cmp++;
        if ({valid, oidx, odata} !== {1'b1, 2'd2, 8'h10}) begin
            n_err++;
            $display("FAIL basic_first_word_latency: valid/idx/data %h required 21 0", {valid, oidx, odata});
        end
        collect(60, 1'b0);
        n_cmp++;
        if (got_n !== 4) begin
            n_err++;
            $display("FAIL basic_count: got %0d required 4", got_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({got_idx[i], got_data[i], got_last[i]} !== {exp_idx[i], exp_data[i], exp_last[i]}) begin
                n_err++;
                $display("FAIL basic_word%0d: idx %0d data %h last %b required idx %0d data %h last %b",
                         i, got_idx[i], got_data[i], got_last[i], exp_idx[i], exp_data[i], exp_last[i]);
            end
        end
        n_cmp++;
        if ((done_cyc - hs_cyc) !== 1 || busy_at_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_timing: done-hs %0d busy %b required 1 and 0", done_cyc - hs_cyc, busy_at_done);
        end
    endtask

    task automatic test_ties();
        data = 32'h5500_5500; mask = 4'b1010; ready = 1'b1;
        force_en = 1'b1; xi_force = 4'b1010;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        collect(60, 1'b0);
        n_cmp++;
        if (got_n !== 2) begin
            n_err++;
            $display("FAIL ties_count: got %0d required 2", got_n);
        end
        n_cmp++;
        if ({got_idx[0], got_last[0], got_idx[1], got_last[1]} !== {2'd1, 1'b0, 2'd3, 1'b1}) begin
            n_err++;
            $display("FAIL ties_order: idx %0d,%0d last %b%b required idx 1,3 last 01",
                     got_idx[0], got_idx[1], got_last[0], got_last[1]);
        end
        n_cmp++;
        if ({got_data[0], got_data[1]} !== 16'h5555) begin
            n_err++;
            $display("FAIL ties_data: got %h required 5555", {got_data[0], got_data[1]});
        end
        force_en = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_idx [4];
        exp_idx = '{2'd2, 2'd0, 2'd1, 2'd3};
        data = 32'h4010_3020; mask = 4'b1111; ready = 1'b1; force_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_cmp++;
            if ({valid, odata, oidx, active} !== {1'b1, 8'h10, 2'd2, 4'b1111}) begin
                n_err++;
                $display("FAIL backpressure_hold%0d: valid/data/idx/active %h required 1 10 2 f", s, {valid, odata, oidx, active});
            end
        end
        ready = 1'b1;
        collect(60, 1'b0);
        n_cmp++;
        if (got_n !== 4) begin
            n_err++;
            $display("FAIL backpressure_count: got %0d required 4", got_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_idx[i] !== exp_idx[i]) begin
                n_err++;
                $display("FAIL backpressure_order%0d: got %0d required %0d", i, got_idx[i], exp_idx[i]);
            end
        end
    endtask

    task automatic test_empty();
        bit saw_valid;
        mask = 4'b0000; ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({done, busy, valid} !== 3'b100) begin
            n_err++;
            $display("FAIL empty_done_pulse: done/busy/valid %b required 100", {done, busy, valid});
        end
        saw_valid = 1'b0;
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL empty_done_width: done %b required 0", done);
        end
        for (int i = 0; i < 4; i++) begin
            if (valid) saw_valid = 1'b1;
            tick();
        end
        n_cmp++;
        if (saw_valid !== 1'b0) begin
            n_err++;
            $display("FAIL empty_no_valid: saw valid %b required 0", saw_valid);
        end
    endtask

    task automatic test_error();
        data = 32'h4010_3020; mask = 4'b0011; ready = 1'b1;
        force_en = 1'b1; xi_force = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if ({err, busy, valid, active, done} !== {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL error_set: err/busy/valid/active/done %b required 10000000", {err, busy, valid, active, done});
        end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL error_sticky: err %b required 1", err);
        end
        force_en = 1'b0; mask = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL error_clear_on_start: err %b required 0", err);
        end
        tick();
        collect(60, 1'b0);
        n_cmp++;
        if ({got_n == 1, got_idx[0], got_data[0], got_last[0]} !== {1'b1, 2'd0, 8'h20, 1'b1}) begin
            n_err++;
            $display("FAIL error_recovery_pass: n %0d idx %0d data %h last %b required 1 0 20 1",
                     got_n, got_idx[0], got_data[0], got_last[0]);
        end
    endtask

    task automatic test_midpass_reset();
        logic [1:0] exp_idx [4];
        exp_idx = '{2'd2, 2'd0, 2'd1, 2'd3};
        data = 32'h4010_3020; mask = 4'b1111; ready = 1'b1; force_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if ({valid, oidx, active} !== {1'b1, 2'd0, 4'b1011}) begin
            n_err++;
            $display("FAIL midpass_second_word: valid/idx/active %b required 1001011", {valid, oidx, active});
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({active, valid, odata, oidx, last, busy, done, err} !== 19'd0) begin
            n_err++;
            $display("FAIL midpass_reset_outputs: got %h required 0", {active, valid, odata, oidx, last, busy, done, err});
        end
        rst = 1'b0;
        tick();
        mask = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        mask = 4'b0001;
        collect(80, 1'b1);
        n_cmp++;
        if (got_n !== 4 || (done_cyc - hs_cyc) !== 1) begin
            n_err++;
            $display("FAIL midpass_restart_count: n %0d done-hs %0d required 4 and 1", got_n, done_cyc - hs_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got_idx[i] !== exp_idx[i]) begin
                n_err++;
                $display("FAIL midpass_ignored_start_order%0d: got %0d required %0d", i, got_idx[i], exp_idx[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_backpressure();
        test_empty();
        test_error();
        test_midpass_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
